// File: rtl/bd_pkg.sv
// Shared types and constants for the baseband receive path.
package bd_pkg;

  // Framing state of the receive controller.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HUNT    = 2'd1,
    ST_LEN     = 2'd2,
    ST_PAYLOAD = 2'd3
  } bd_rx_state_t;

  // Host command bit positions.
  localparam int CMD_EN      = 0;
  localparam int CMD_CLR_OVF = 1;
  localparam int CMD_FLUSH   = 2;

  // Default framing constants.
  localparam logic [7:0] SYNC_DEFAULT    = 8'h7E;
  localparam logic [7:0] MAX_LEN_DEFAULT = 8'd32;

  // A LEN byte is usable when it is non-zero and no larger than max_len.
  function automatic logic len_in_range(input logic [7:0] len, input logic [7:0] max_len);
    return (len != 8'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/bd_rx_fifo.sv
// Payload byte FIFO with a registered head (data_out/valid) so the host
// sees a byte one cycle after it is written into an empty FIFO.
module bd_rx_fifo
  import bd_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [7:0]             wr_data,
  input  logic                   rd,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   valid,
  output logic [7:0]             head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nx_s, rd_ptr_nx_s;
  logic [AW:0]   count_r, count_nx_s, count_after_rd_s;
  logic          valid_r, valid_nx_s;
  logic [7:0]    head_r, head_nx_s;
  logic          wr_ok_s, rd_ok_s;

  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == CNT_ZERO);
  assign count = count_r;
  assign valid = valid_r;
  assign head  = head_r;

  // Next-state: accepted write/read, pointer/count update and the next head byte.
  always_comb begin
    wr_ok_s          = wr && !full && !flush;
    rd_ok_s          = rd && !empty && !flush;
    count_after_rd_s = rd_ok_s ? (count_r - CNT_ONE) : count_r;
    rd_ptr_nx_s      = rd_ok_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    wr_ptr_nx_s      = wr_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    count_nx_s       = wr_ok_s ? (count_after_rd_s + CNT_ONE) : count_after_rd_s;
    valid_nx_s       = 1'b0;
    head_nx_s        = 8'h00;
    if (flush) begin
      rd_ptr_nx_s = PTR_ZERO;
      wr_ptr_nx_s = PTR_ZERO;
      count_nx_s  = CNT_ZERO;
    end else if (count_nx_s == CNT_ZERO) begin
      valid_nx_s = 1'b0;
    end else if (count_after_rd_s == CNT_ZERO) begin
      // The only byte left after this cycle is the one being written now.
      valid_nx_s = 1'b1;
      head_nx_s  = wr_data;
    end else begin
      valid_nx_s = 1'b1;
      head_nx_s  = mem_r[rd_ptr_nx_s];
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      valid_r  <= 1'b0;
      head_r   <= 8'h00;
    end else begin
      wr_ptr_r <= wr_ptr_nx_s;
      rd_ptr_r <= rd_ptr_nx_s;
      count_r  <= count_nx_s;
      valid_r  <= valid_nx_s;
      head_r   <= head_nx_s;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/bd_rx_ctrl.sv
// Receive-path controller: demodulator enable, SYNC/LEN/payload framing,
// payload buffering and frame-complete interrupt toward the host.
module bd_rx_ctrl
  import bd_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter logic [7:0] MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic       G_CLK_RX,
  input  logic       RST_RX,
  input  logic       dec_valid,
  input  logic [7:0] dec_data,
  output logic       bd_control,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  output logic       ready_in,
  output logic       valid_out,
  output logic [7:0] data_out,
  input  logic       ready_out,
  output logic       int_rx_host,
  output logic       overflow
);

  bd_rx_state_t state_r, state_nx_s;
  logic [7:0]   cnt_r, cnt_nx_s;
  logic         en_r, ready_in_r, int_r, ovf_r;
  logic         int_nx_s, fifo_wr_s, ovf_set_s;
  logic         cmd_clr_s, cmd_flush_s;
  logic         fifo_full_s, fifo_empty_s;
  logic [$clog2(DEPTH):0] fifo_count_s;
  logic         unused_s;

  assign cmd_clr_s   = valid_in && data_in[CMD_CLR_OVF];
  assign cmd_flush_s = valid_in && data_in[CMD_FLUSH];

  // The enable register is the demodulator enable itself: one cycle after the command.
  assign bd_control  = en_r;
  assign ready_in    = ready_in_r;
  assign int_rx_host = int_r;
  assign overflow    = ovf_r;
  assign unused_s    = &{1'b0, fifo_count_s, fifo_empty_s};

  // Command register: enable bit and command-ready flag.
  always_ff @(posedge G_CLK_RX or posedge RST_RX) begin
    if (RST_RX) begin
      en_r       <= 1'b0;
      ready_in_r <= 1'b0;
    end else begin
      ready_in_r <= 1'b1;
      if (valid_in) begin
        en_r <= data_in[CMD_EN];
      end
    end
  end

  // Framing FSM next-state, byte counter, FIFO write and drop detection.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    fifo_wr_s  = 1'b0;
    ovf_set_s  = 1'b0;
    int_nx_s   = 1'b0;
    if (!en_r) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_HUNT;
        end
        ST_HUNT: begin
          if (dec_valid && (dec_data == SYNC)) begin
            state_nx_s = ST_LEN;
          end else begin
            state_nx_s = ST_HUNT;
          end
        end
        ST_LEN: begin
          if (dec_valid && len_in_range(dec_data, MAX_LEN)) begin
            cnt_nx_s   = dec_data;
            state_nx_s = ST_PAYLOAD;
          end else if (dec_valid) begin
            state_nx_s = ST_HUNT;
          end else begin
            state_nx_s = ST_LEN;
          end
        end
        ST_PAYLOAD: begin
          if (dec_valid) begin
            fifo_wr_s = !fifo_full_s;
            ovf_set_s = fifo_full_s;
            cnt_nx_s  = cnt_r - 8'd1;
            if (cnt_r == 8'd1) begin
              int_nx_s   = 1'b1;
              state_nx_s = ST_HUNT;
            end else begin
              state_nx_s = ST_PAYLOAD;
            end
          end else begin
            state_nx_s = ST_PAYLOAD;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state, byte counter, interrupt pulse and sticky overflow registers.
  always_ff @(posedge G_CLK_RX or posedge RST_RX) begin
    if (RST_RX) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      int_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      int_r   <= int_nx_s;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (cmd_clr_s) begin
        ovf_r <= 1'b0;
      end
    end
  end

  bd_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (G_CLK_RX),
    .rst     (RST_RX),
    .wr      (fifo_wr_s),
    .wr_data (dec_data),
    .rd      (ready_out),
    .flush   (cmd_flush_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s),
    .valid   (valid_out),
    .head    (data_out)
  );

endmodule

// File: tb/tb_bd_rx_ctrl.sv
// Directed self-checking bench for bd_rx_ctrl (DEPTH=16, SYNC=7E, MAX_LEN=32).
module tb_bd_rx_ctrl;

  logic       G_CLK_RX = 1'b0;
  logic       RST_RX;
  logic       dec_valid;
  logic [7:0] dec_data;
  logic       bd_control;
  logic       valid_in;
  logic [7:0] data_in;
  logic       ready_in;
  logic       valid_out;
  logic [7:0] data_out;
  logic       ready_out;
  logic       int_rx_host;
  logic       overflow;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  bd_rx_ctrl #(
    .DEPTH   (16),
    .SYNC    (8'h7E),
    .MAX_LEN (8'd32)
  ) dut (
    .G_CLK_RX    (G_CLK_RX),
    .RST_RX      (RST_RX),
    .dec_valid   (dec_valid),
    .dec_data    (dec_data),
    .bd_control  (bd_control),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .ready_in    (ready_in),
    .valid_out   (valid_out),
    .data_out    (data_out),
    .ready_out   (ready_out),
    .int_rx_host (int_rx_host),
    .overflow    (overflow)
  );

  always #5 G_CLK_RX = ~G_CLK_RX;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge G_CLK_RX);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    dec_valid = 1'b1;
    dec_data  = b;
    tick();
    dec_valid = 1'b0;
  endtask

  task automatic command(input logic [7:0] c);
    valid_in = 1'b1;
    data_in  = c;
    tick();
    valid_in = 1'b0;
  endtask

  // One cycle of the backpressure test with a queue scoreboard; ready_out toggles.
  task automatic cyc(input logic dv, input logic [7:0] d, input logic pay);
    dec_valid = dv;
    dec_data  = d;
    chk1("bp_valid", valid_out, exp_q.size() != 0);
    if (valid_out && ready_out && (exp_q.size() != 0)) begin
      chk8("bp_data", data_out, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (pay) exp_q.push_back(d);
    tick();
    dec_valid = 1'b0;
    ready_out = ~ready_out;
  endtask

  initial begin
    RST_RX = 1'b1; dec_valid = 1'b0; dec_data = 8'h00;
    valid_in = 1'b0; data_in = 8'h00; ready_out = 1'b0;
    #12;
    chk1("rst_bd_control", bd_control, 1'b0);
    chk1("rst_ready_in", ready_in, 1'b0);
    chk1("rst_valid_out", valid_out, 1'b0);
    chk8("rst_data_out", data_out, 8'h00);
    chk1("rst_int", int_rx_host, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    @(posedge G_CLK_RX); #1;
    RST_RX = 1'b0;
    tick();
    chk1("post_rst_ready_in", ready_in, 1'b1);
    chk1("post_rst_bd_control", bd_control, 1'b0);

    // Basic frame
    command(8'h01);
    chk1("en_bd_control", bd_control, 1'b1);
    tick();
    ready_out = 1'b1;
    send(8'h7E); send(8'h03);
    chk1("basic_no_early_valid", valid_out, 1'b0);
    send(8'hA1);
    chk1("basic_v1", valid_out, 1'b1); chk8("basic_d1", data_out, 8'hA1);
    chk1("basic_no_int1", int_rx_host, 1'b0);
    send(8'hB2);
    chk1("basic_v2", valid_out, 1'b1); chk8("basic_d2", data_out, 8'hB2);
    chk1("basic_no_int2", int_rx_host, 1'b0);
    send(8'hC3);
    chk1("basic_v3", valid_out, 1'b1); chk8("basic_d3", data_out, 8'hC3);
    chk1("basic_int", int_rx_host, 1'b1);
    tick();
    chk1("basic_int_once", int_rx_host, 1'b0);
    chk1("basic_drained", valid_out, 1'b0);

    // Bad LEN
    send(8'h7E); send(8'h00); send(8'h7E); send(8'h01);
    chk1("badlen_nothing", valid_out, 1'b0);
    chk1("badlen_no_int", int_rx_host, 1'b0);
    send(8'h55);
    chk1("badlen_v", valid_out, 1'b1); chk8("badlen_d", data_out, 8'h55);
    chk1("badlen_int", int_rx_host, 1'b1);
    tick();
    chk1("badlen_int_once", int_rx_host, 1'b0);
    chk1("badlen_drained", valid_out, 1'b0);

    // Overflow: LEN=20 into a 16-byte FIFO with no reads
    ready_out = 1'b0;
    send(8'h7E); send(8'd20);
    for (int i = 0; i < 20; i++) begin
      send(8'(i));
      if (i == 15) chk1("ovf_not_yet", overflow, 1'b0);
      if (i == 16) chk1("ovf_set", overflow, 1'b1);
      if (i == 18) chk1("ovf_no_int_early", int_rx_host, 1'b0);
      if (i == 19) chk1("ovf_int", int_rx_host, 1'b1);
    end
    chk1("ovf_head_v", valid_out, 1'b1); chk8("ovf_head_d", data_out, 8'h00);
    tick();
    chk1("ovf_int_once", int_rx_host, 1'b0);
    chk1("ovf_sticky", overflow, 1'b1);
    command(8'h03);
    chk1("ovf_cleared", overflow, 1'b0);
    chk1("ovf_keep_en", bd_control, 1'b1);
    ready_out = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk1("ovf_drain_v", valid_out, 1'b1);
      chk8("ovf_drain_d", data_out, 8'(i));
      tick();
    end
    chk1("ovf_drain_empty", valid_out, 1'b0);

    // Backpressure and wrap: 2 frames x 20 bytes, ready_out toggling
    ready_out = 1'b0;
    for (int f = 0; f < 2; f++) begin
      cyc(1'b1, 8'h7E, 1'b0); cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'd20, 1'b0); cyc(1'b0, 8'h00, 1'b0);
      for (int j = 0; j < 20; j++) begin
        cyc(1'b1, 8'(64 + f * 20 + j), 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
      end
    end
    for (int n = 0; n < 64 && exp_q.size() != 0; n++) cyc(1'b0, 8'h00, 1'b0);
    chk1("bp_all_delivered", exp_q.size() == 0, 1'b1);
    chk1("bp_final_empty", valid_out, 1'b0);
    chk1("bp_no_overflow", overflow, 1'b0);

    // Flush colliding with a payload write
    ready_out = 1'b0;
    send(8'h7E); send(8'h03); send(8'h11);
    chk1("fl_pre_v", valid_out, 1'b1); chk8("fl_pre_d", data_out, 8'h11);
    dec_valid = 1'b1; dec_data = 8'h22;
    valid_in = 1'b1; data_in = 8'h05;
    tick();
    dec_valid = 1'b0; valid_in = 1'b0;
    chk1("fl_empty", valid_out, 1'b0);
    chk1("fl_keep_en", bd_control, 1'b1);
    send(8'h33);
    chk1("fl_post_v", valid_out, 1'b1); chk8("fl_post_d", data_out, 8'h33);
    chk1("fl_int", int_rx_host, 1'b1);
    ready_out = 1'b1;
    tick();
    chk1("fl_drained", valid_out, 1'b0);

    // Disable after 2 of 4 payload bytes
    ready_out = 1'b0;
    send(8'h7E); send(8'h04); send(8'hD1); send(8'hD2);
    command(8'h00);
    chk1("dis_bd_control", bd_control, 1'b0);
    chk1("dis_no_int0", int_rx_host, 1'b0);
    send(8'hD3);
    chk1("dis_no_int1", int_rx_host, 1'b0);
    tick();
    chk1("dis_no_int2", int_rx_host, 1'b0);
    ready_out = 1'b1;
    chk1("dis_v1", valid_out, 1'b1); chk8("dis_d1", data_out, 8'hD1);
    tick();
    chk1("dis_v2", valid_out, 1'b1); chk8("dis_d2", data_out, 8'hD2);
    tick();
    chk1("dis_only2", valid_out, 1'b0);

    // Reset mid-frame
    command(8'h01);
    tick();
    ready_out = 1'b0;
    send(8'h7E); send(8'h04); send(8'hE1);
    chk1("rstmid_pre_v", valid_out, 1'b1);
    #2;
    RST_RX = 1'b1;
    #1;
    chk1("rstmid_bd_control", bd_control, 1'b0);
    chk1("rstmid_ready_in", ready_in, 1'b0);
    chk1("rstmid_valid_out", valid_out, 1'b0);
    chk8("rstmid_data_out", data_out, 8'h00);
    chk1("rstmid_int", int_rx_host, 1'b0);
    chk1("rstmid_overflow", overflow, 1'b0);
    @(posedge G_CLK_RX); #1;
    RST_RX = 1'b0;
    tick();
    chk1("rstmid_after_ready_in", ready_in, 1'b1);
    chk1("rstmid_after_valid", valid_out, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bd_rx_ctrl.md
# bd_rx_ctrl

Receive-path controller for the baseband (BD) datapath. Enables and disables the demodulator, frames the decoded byte stream (SYNC, LEN, payload), and buffers payload bytes in a small FIFO. Delivers the buffered bytes to the host over a valid/ready stream and raises `int_rx_host` when a frame completes. Sits between the decoder output and the host-side AMBA stream, in the `G_CLK_RX` domain.

## Interface
- `DEPTH`, 16: FIFO depth in bytes. Power of two, ≥ 2.
- `SYNC`, 8'h7E: frame start byte.
- `MAX_LEN`, 8'd32: largest legal LEN value.
- `G_CLK_RX`  in  1  receive clock; all logic is on its rising edge.
- `RST_RX`  in  1  reset, asynchronous, active-high.
- `dec_valid`  in  1  decoder presents a byte this cycle (single-cycle strobe, no backpressure).
- `dec_data`  in  8  decoded byte.
- `bd_control`  out  1  demodulator enable.
- `valid_in`  in  1  host command valid.
- `data_in`  in  8  host command: bit0 = enable, bit1 = clear overflow (write-1), bit2 = flush FIFO (write-1).
- `ready_in`  out  1  command ready. Constant 1 out of reset.
- `valid_out`  out  1  FIFO head valid toward host.
- `data_out`  out  8  FIFO head byte.
- `ready_out`  in  1  host accepts the byte.
- `int_rx_host`  out  1  frame-complete pulse, one cycle.
- `overflow`  out  1  sticky: a payload byte was dropped.

## Operation
- **Reset values:** `bd_control`=0, `ready_in`=0 during reset (1 after), `valid_out`=0, `data_out`=0, `int_rx_host`=0, `overflow`=0. FSM in IDLE, FIFO empty.
- **Command accepted when `valid_in`:**
  - enable ← `data_in[0]`; `bd_control` follows on the next cycle.
  - bit1 clears `overflow`.
  - bit2 empties the FIFO.
- **FSM states:** IDLE, HUNT, LEN, PAYLOAD.
  - IDLE: `bd_control`=0. Goes to HUNT when enable=1.
  - HUNT: wait for a `dec_valid` byte equal to `SYNC`, then go to LEN. Other bytes are ignored.
  - LEN: on `dec_valid`, if the byte is in 1..`MAX_LEN`, load the byte counter and go to PAYLOAD. Otherwise go back to HUNT.
  - PAYLOAD: each `dec_valid` byte is written to the FIFO if the FIFO is not full. If full, the byte is dropped and `overflow` is set. The counter decrements per byte either way. When the counter reaches 0 on the last byte, pulse `int_rx_host` on the next cycle and go to HUNT.
- **Enable deasserted in any state:** go to IDLE on the next cycle. A partial frame already in the FIFO is kept and no interrupt is raised.
- **FIFO:**
  - Write full check uses the pre-cycle count. A write is rejected when full even if a read happens in the same cycle.
  - A read occurs on `valid_out && ready_out`.
  - Flush in the same cycle as a write or read: flush wins, the written byte is discarded, and the count becomes 0.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally. The count is `$clog2(DEPTH)+1` bits.
- **Overflow:** setting wins over clearing when both occur in the same cycle.
- **Frame with `overflow` set:** still ends with `int_rx_host`. The host checks `overflow`.

## Timing
- `dec_valid` byte → `valid_out` high: 1 cycle when the FIFO was empty. `data_out` is registered.
- `valid_out` stays asserted and `data_out` stays stable until the handshake completes. Back-to-back reads run at 1 byte/cycle.
- `int_rx_host` is high exactly 1 cycle, the cycle after the last payload `dec_valid`.
- Command → `bd_control` change: 1 cycle.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously). Buffered data is lost.

## Structure
- Package `bd_pkg`:
  - `bd_rx_state_t` enum (IDLE, HUNT, LEN, PAYLOAD).
  - Command bit indices `CMD_EN`, `CMD_CLR_OVF`, `CMD_FLUSH`.
  - Default `SYNC` constant.
- Sub-module `bd_rx_fifo`: synchronous FIFO with wr/rd/flush inputs and full/empty/count outputs. The FSM and command register live in `bd_rx_ctrl`.

## Test plan
- **Basic frame:** enable; send 7E, 03, A1, B2, C3 with `ready_out`=1 → `valid_out` carries A1, B2, C3 on consecutive cycles. One `int_rx_host` pulse, the cycle after C3.
- **Bad LEN:** send 7E, 00, 7E, 01, 55 → only 55 is buffered. One interrupt.
- **Overflow:** `DEPTH`=16, `ready_out`=0, frame LEN=20 → 16 bytes buffered, `overflow`=1, interrupt still pulses. Command 0x03 clears `overflow` and keeps enable.
- **Backpressure and wrap:** toggle `ready_out` every other cycle across 40 bytes in 2 frames → output order preserved, no loss, pointers wrap.
- **Flush collision:** flush command in the same cycle as a payload write → FIFO empty next cycle, `valid_out`=0.
- **Disable and reset mid-frame:** disable after 2 of 4 payload bytes → 2 bytes kept, no interrupt, `bd_control`=0 next cycle. `RST_RX` pulse mid-frame → all outputs 0 immediately.
